// File: rtl/alu_result_writer.sv
// Result collector: arbitrates adder/multiplier results into a tagged FIFO and
// presents them downstream. Define ALU_RESWR_STATS_EN to add the stall_cnt port.
module alu_result_writer #(
  parameter int DATA_SIZE = 16,
  parameter int ID_SIZE   = 8,
  parameter int DEPTH     = 4,
  localparam int RES_W    = DATA_SIZE + 1 + ID_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid_res,
  input  logic [RES_W-1:0] result_add,
  output logic             sum_written,
  input  logic             m_valid_res,
  input  logic [RES_W-1:0] result_mul,
  output logic             mul_written,
  output logic             ready_f_res,
  output logic             out_valid,
  output logic [RES_W:0]   out_data,
`ifdef ALU_RESWR_STATS_EN
  output logic [15:0]      stall_cnt,
`endif
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_MUL = 1'b1;

  typedef enum logic [0:0] {IDLE, ACK} state_t;

  state_t       state, next_state;
  logic         last_grant;
  logic         sel;
  logic         push, pop, full;
  logic [RES_W:0] push_word;

  logic [RES_W:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign ready_f_res = (count <= CW'(DEPTH - 2));

  // Strobes come from registered state only, never from the valid inputs.
  assign sum_written = (state == ACK) && (last_grant == SRC_ADD);
  assign mul_written = (state == ACK) && (last_grant == SRC_MUL);
  assign push_word   = {sel, (sel == SRC_MUL) ? result_mul : result_add};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_MUL;
    end else begin
      state <= next_state;
      if (push) last_grant <= sel;
    end
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    sel        = SRC_ADD;
    case (state)
      IDLE: begin
        if (!full && (a_valid_res || m_valid_res)) begin
          if (a_valid_res && m_valid_res) sel = ~last_grant;
          else                            sel = m_valid_res ? SRC_MUL : SRC_ADD;
          push       = 1'b1;
          next_state = ACK;
        end
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

`ifdef ALU_RESWR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && (a_valid_res || m_valid_res) && full
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_writer.sv
// Directed self-checking bench for alu_result_writer (default parameters).
module tb_alu_result_writer;

  localparam int RES_W = 25;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid_res;
  logic [RES_W-1:0] result_add;
  logic             sum_written;
  logic             m_valid_res;
  logic [RES_W-1:0] result_mul;
  logic             mul_written;
  logic             ready_f_res;
  logic             out_valid;
  logic [RES_W:0]   out_data;
  logic             out_ready;
`ifdef ALU_RESWR_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  alu_result_writer dut (
    .clk(clk), .rst(rst),
    .a_valid_res(a_valid_res), .result_add(result_add), .sum_written(sum_written),
    .m_valid_res(m_valid_res), .result_mul(result_mul), .mul_written(mul_written),
    .ready_f_res(ready_f_res), .out_valid(out_valid), .out_data(out_data),
`ifdef ALU_RESWR_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] make_res(input logic [7:0] id, input logic c,
                                                input logic [15:0] d);
    return {id, c, d};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_valid_res = 1'b0; m_valid_res = 1'b0; out_ready = 1'b0;
    result_add = '0; result_mul = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Holds one source's valid until its ack shows up, with a bounded wait.
  task automatic send(input logic src, input logic [RES_W-1:0] res);
    bit got = 0;
    if (src) begin result_mul = res; m_valid_res = 1'b1; end
    else     begin result_add = res; a_valid_res = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (src ? mul_written : sum_written) begin got = 1; break; end
    end
    if (src) m_valid_res = 1'b0; else a_valid_res = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL send_ack_timeout src=%0d got no ack, required ack within 20 cycles", src);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sum_written got %b want 0", sum_written); end
    if (mul_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mul_written got %b want 0", mul_written); end
    if (ready_f_res !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b want 1", ready_f_res); end
  endtask

  task automatic test_single_add();
    logic [RES_W:0] exp_word;
    do_reset();
    exp_word = {1'b0, 8'h05, 1'b0, 16'h1234};
    result_add = make_res(8'h05, 1'b0, 16'h1234);
    a_valid_res = 1'b1;
    tests_run++;
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_early_ack got %b want 0", sum_written); end
    @(posedge clk); #1;
    tests_run += 3;
    if (sum_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_ack got %b want 1", sum_written); end
    if (mul_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_wrong_ack got %b want 0", mul_written); end
    if (out_data !== exp_word) begin tests_failed++; $display("[TB] FAIL add_data got %h want %h", out_data, exp_word); end
    a_valid_res = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_ack_one_cycle got %b want 0", sum_written); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_single_entry got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_tie();
    logic [RES_W-1:0] ra, rm;
    do_reset();
    ra = make_res(8'h01, 1'b1, 16'hAAAA);
    rm = make_res(8'h02, 1'b0, 16'h5555);
    result_add = ra; result_mul = rm;
    a_valid_res = 1'b1; m_valid_res = 1'b1;
    @(posedge clk); #1;
    tests_run += 2;
    if (sum_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie_first_add got %b want 1", sum_written); end
    if (mul_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_first_mul got %b want 0", mul_written); end
    a_valid_res = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (mul_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_mul_early got %b want 0", mul_written); end
    @(posedge clk); #1;
    tests_run += 2;
    if (mul_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie_mul_ack got %b want 1", mul_written); end
    if (out_data !== {1'b0, ra}) begin tests_failed++; $display("[TB] FAIL tie_head_add got %h want %h", out_data, {1'b0, ra}); end
    m_valid_res = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_data !== {1'b1, rm}) begin tests_failed++; $display("[TB] FAIL tie_head_mul got %h want %h", out_data, {1'b1, rm}); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_drained got %b want 0", out_valid); end
    a_valid_res = 1'b1; m_valid_res = 1'b1;
    @(posedge clk); #1;
    tests_run += 2;
    if (sum_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie_second_add got %b want 1", sum_written); end
    if (mul_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL tie_second_mul got %b want 0", mul_written); end
    a_valid_res = 1'b0; m_valid_res = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    send(1'b0, make_res(8'd10, 1'b0, 16'hA00A));
    send(1'b0, make_res(8'd11, 1'b0, 16'hA00B));
    tests_run++;
    if (ready_f_res !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_ready_at2 got %b want 1", ready_f_res); end
    send(1'b0, make_res(8'd12, 1'b0, 16'hA00C));
    tests_run++;
    if (ready_f_res !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ready_at3 got %b want 0", ready_f_res); end
    send(1'b0, make_res(8'd13, 1'b0, 16'hA00D));
    result_add = make_res(8'd14, 1'b1, 16'hA00E);
    a_valid_res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_ack cycle %0d got %b want 0", i, sum_written); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run += 2;
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_ack_at_pop got %b want 0", sum_written); end
    if (out_data !== {1'b0, make_res(8'd11, 1'b0, 16'hA00B)}) begin
      tests_failed++; $display("[TB] FAIL full_head_after_pop got %h want %h", out_data, {1'b0, make_res(8'd11, 1'b0, 16'hA00B)});
    end
    @(posedge clk); #1;
    tests_run++;
    if (sum_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_fifth_ack got %b want 1", sum_written); end
    a_valid_res = 1'b0;
    out_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      tests_run++;
      if (out_data !== {1'b0, make_res(8'(k), (k == 14), 16'hA000 + 16'(k))}) begin
        tests_failed++; $display("[TB] FAIL full_drain id %0d got %h want %h", k, out_data, {1'b0, make_res(8'(k), (k == 14), 16'hA000 + 16'(k))});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [RES_W:0] q[$];
    logic [RES_W-1:0] r;
    logic src;
    do_reset();
    r = make_res(8'd20, 1'b0, 16'h0020); send(1'b0, r); q.push_back({1'b0, r});
    r = make_res(8'd21, 1'b1, 16'h0021); send(1'b1, r); q.push_back({1'b1, r});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_data !== q[0]) begin tests_failed++; $display("[TB] FAIL wrap_head %0d got %h want %h", i, out_data, q[0]); end
      src = 1'(i % 2);
      r = make_res(8'(22 + i), src, 16'h1000 + 16'(i));
      if (src) begin result_mul = r; m_valid_res = 1'b1; end
      else     begin result_add = r; a_valid_res = 1'b1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      void'(q.pop_front());
      q.push_back({src, r});
      tests_run += 2;
      if ((src ? mul_written : sum_written) !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_ack %0d got 0 want 1", i); end
      if (ready_f_res !== 1'b1 || out_valid !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL wrap_count %0d got ready %b valid %b want 1 1", i, ready_f_res, out_valid);
      end
      a_valid_res = 1'b0; m_valid_res = 1'b0; out_ready = 1'b0;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tests_run++;
      if (out_data !== q[0]) begin tests_failed++; $display("[TB] FAIL wrap_drain %0d got %h want %h", j, out_data, q[0]); end
      void'(q.pop_front());
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_in_ack();
    logic [RES_W-1:0] r;
    do_reset();
    r = make_res(8'd30, 1'b0, 16'hBEEF);
    result_add = r;
    a_valid_res = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests_run += 3;
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstack_strobe got %b want 0", sum_written); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstack_out_valid got %b want 0", out_valid); end
    if (ready_f_res !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstack_ready got %b want 1", ready_f_res); end
    @(posedge clk); #1;
    tests_run++;
    if (sum_written !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstack_held_strobe got %b want 0", sum_written); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run += 2;
    if (sum_written !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstack_recapture got %b want 1", sum_written); end
    if (out_data !== {1'b0, r}) begin tests_failed++; $display("[TB] FAIL rstack_data got %h want %h", out_data, {1'b0, r}); end
    a_valid_res = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef ALU_RESWR_STATS_EN
  task automatic test_stats();
    do_reset();
    tests_run++;
    if (stall_cnt !== 16'd0) begin tests_failed++; $display("[TB] FAIL stats_reset got %0d want 0", stall_cnt); end
    for (int i = 0; i < 4; i++) send(1'b0, make_res(8'(40 + i), 1'b0, 16'h4000));
    @(posedge clk); #1;
    a_valid_res = 1'b1;
    repeat (7) @(posedge clk);
    #1 a_valid_res = 1'b0;
    tests_run++;
    if (stall_cnt !== 16'd7) begin tests_failed++; $display("[TB] FAIL stats_count got %0d want 7", stall_cnt); end
    @(posedge clk); #1;
    tests_run++;
    if (stall_cnt !== 16'd7) begin tests_failed++; $display("[TB] FAIL stats_hold got %0d want 7", stall_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_tie();
    test_full();
    test_back_to_back();
    test_reset_in_ack();
`ifdef ALU_RESWR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
